// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: group count,
// configuration check and the per-transaction arithmetic mode.
package cla_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  function automatic int nblk(input int n, input int blk);
    return (blk > 0) ? n / blk : 1;
  endfunction

  function automatic bit cfg_ok(input int n, input int blk);
    return (blk > 0) && (n >= blk) && (n % blk == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: BLOCK-bit sum plus group generate/propagate,
// carry-out and the carry into the group MSB (for signed overflow).
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             g,
  output logic             p,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] gen;
  logic [BLOCK-1:0] prop;
  logic [BLOCK-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves a value unassigned and no latch can be inferred.
    c    = '0;
    g    = 1'b0;
    p    = 1'b1;
    c[0] = cin;
    for (int i = 1; i < BLOCK; i++) begin
      c[i] = gen[i-1] | (prop[i-1] & c[i-1]);
    end
    for (int i = 0; i < BLOCK; i++) begin
      g = gen[i] | (prop[i] & g);
      p = p & prop[i];
    end
  end

  assign sum   = prop ^ c;
  assign cout  = g | (p & cin);
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// N-bit adder split into NBLK lookahead groups, one group per pipeline stage,
// with valid/ready flow control and per-transaction signed/unsigned mode.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int N     = 12,
  parameter int BLOCK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   sum,
  output logic         ovf
);

  localparam int NBLK = nblk(N, BLOCK);
  localparam int LAST = NBLK - 1;

  if (!cfg_ok(N, BLOCK)) begin : g_cfg_check
    $error("cla_pipe_adder: N must be a non-zero multiple of BLOCK");
  end

  // Stage k register: word_q holds finished sum bits in the top (k+1)*BLOCK
  // positions and the not-yet-used A bits below; b_q holds the unused B bits.
  logic [NBLK-1:0] valid_q;
  logic [NBLK-1:0] carry_q;
  mode_e           sign_q [NBLK];
  logic [N-1:0]    word_q [NBLK];
  logic [N-1:0]    b_q    [NBLK];
  logic            ovf_q;

  logic [N-1:0]     w_in     [NBLK];
  logic [N-1:0]     b_in     [NBLK];
  logic [NBLK-1:0]  c_in;
  mode_e            s_in     [NBLK];
  logic [BLOCK-1:0] grp_sum  [NBLK];
  logic [NBLK-1:0]  grp_g;
  logic [NBLK-1:0]  grp_p;
  logic [NBLK-1:0]  grp_cout;
  logic [NBLK-1:0]  grp_cmsb;

  logic stall;
  logic sum_top;
  logic unused_bits;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_in[k] = a;
      assign b_in[k] = b;
      assign c_in[k] = cin;
      assign s_in[k] = mode_e'(is_signed);
    end else begin : g_tail
      assign w_in[k] = word_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = carry_q[k-1];
      assign s_in[k] = sign_q[k-1];
    end

    cla_group #(.BLOCK(BLOCK)) u_group (
      .a     (w_in[k][BLOCK-1:0]),
      .b     (b_in[k][BLOCK-1:0]),
      .cin   (c_in[k]),
      .sum   (grp_sum[k]),
      .g     (grp_g[k]),
      .p     (grp_p[k]),
      .cout  (grp_cout[k]),
      .c_msb (grp_cmsb[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < NBLK; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // NOTE: only the valid bits are reset; data and skew registers are
  // qualified by valid, so clearing them would just cost reset routing.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 0; k < NBLK; k++) begin
        word_q[k]  <= (w_in[k] >> BLOCK) | (N'(grp_sum[k]) << (N - BLOCK));
        b_q[k]     <= b_in[k] >> BLOCK;
        carry_q[k] <= grp_cout[k];
        sign_q[k]  <= s_in[k];
      end
      ovf_q <= (s_in[LAST] == MODE_SIGNED) && (grp_cmsb[LAST] ^ grp_cout[LAST]);
    end
  end

  // Signed: true sign is the N-bit result MSB, flipped when it overflowed.
  assign sum_top   = (sign_q[LAST] == MODE_SIGNED) ? (word_q[LAST][N-1] ^ ovf_q)
                                                   : carry_q[LAST];
  assign out_valid = valid_q[LAST];
  assign sum       = out_valid ? {sum_top, word_q[LAST]} : '0;
  assign ovf       = out_valid & ovf_q;

  assign unused_bits = ^{grp_g, grp_p, grp_cmsb, b_q[LAST]};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corner cases, backpressure,
// mid-flight reset and a randomized run against an integer reference model.
module tb_cla_pipe_adder;

  localparam int N     = 12;
  localparam int BLOCK = 4;
  localparam int NBLK  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   sum;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int del_cnt = 0;

  logic [N+1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [N:0]   prev_sum   = '0;
  logic         prev_ovf   = 1'b0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.N(N), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on extended operands; returns {ovf, sum}.
  function automatic logic [N+1:0] ref_model(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                             input logic fc, input logic fs);
    longint ia, ib, r, lim;
    logic [63:0] rv;
    logic        f_ovf;
    lim   = longint'(1) << (N - 1);
    ia    = fs ? longint'($signed(fa)) : longint'(fa);
    ib    = fs ? longint'($signed(fb)) : longint'(fb);
    r     = ia + ib + longint'(fc);
    rv    = r;
    f_ovf = fs && ((r >= lim) || (r < -lim));
    return {f_ovf, rv[N:0]};
  endfunction

  // Scoreboard: record accepts, compare deliveries, watch hold-while-stalled.
  always @(negedge clk) begin
    logic [N+1:0] e;
    if (!rst_n) begin
      acc_cnt -= exp_q.size();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, prev_sum);
        check("hold_ovf", ovf, prev_ovf);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a, b, cin, is_signed));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e[N:0]);
          check("ovf", ovf, e[N+1]);
          del_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_ovf   = ovf;
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic tc, input logic ts);
    int waited = 0;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tc;
    is_signed = ts;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_in_time", waited < 50, 1);
    @(posedge clk);
    #1;
  endtask

  // Result is expected in the NBLK-th cycle after the accepting cycle.
  task automatic lat_test(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tc, input logic ts, input logic [N:0] e_sum, input logic e_ovf);
    int lat = 0;
    send(ta, tb, tc, ts);
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, NBLK);
    check({tag, "_sum"}, sum, e_sum);
    check({tag, "_ovf"}, ovf, e_ovf);
    idle(2);
  endtask

  task automatic mixed_test();
    int w = 0;
    send(12'hFFF, 12'h001, 1'b0, 1'b0);
    send(12'h800, 12'h800, 1'b0, 1'b1);
    send(12'h123, 12'h456, 1'b0, 1'b0);
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 20);
    check("mix0_sum", sum, 13'h1000);
    check("mix0_ovf", ovf, 0);
    @(negedge clk);
    check("mix1_valid", out_valid, 1);
    check("mix1_sum", sum, 13'h1000);
    check("mix1_ovf", ovf, 1);
    @(negedge clk);
    check("mix2_valid", out_valid, 1);
    check("mix2_sum", sum, 13'h0579);
    check("mix2_ovf", ovf, 0);
    idle(2);
  endtask

  task automatic backpressure_test();
    int d0 = del_cnt;
    int w  = 0;
    out_ready = 1'b0;
    fork
      begin
        send(12'h0AB, 12'h0CD, 1'b1, 1'b0);
        send(12'h7FF, 12'h7FF, 1'b1, 1'b1);
        send(12'h800, 12'hFFF, 1'b0, 1'b1);
        send(12'hF0F, 12'h0F1, 1'b0, 1'b0);
        send(12'h555, 12'hAAA, 1'b1, 1'b1);
        in_valid = 1'b0;
      end
      begin
        logic [N:0] s0;
        int wr = 0;
        do begin
          @(negedge clk);
          wr++;
        end while (!out_valid && wr < 20);
        check("bp_rise", out_valid, 1);
        s0 = sum;
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_sum_hold", sum, s0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    while ((del_cnt - d0) < 5 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("bp_delivered", del_cnt - d0, 5);
    idle(2);
  endtask

  task automatic reset_test();
    send(12'h321, 12'h123, 1'b0, 1'b0);
    send(12'hABC, 12'h111, 1'b1, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    idle(1);
    lat_test("post_rst", 12'h00F, 12'h001, 1'b0, 1'b0, 13'h0010, 1'b0);
  endtask

  task automatic random_test();
    int start_acc = acc_cnt;
    int cyc       = 0;
    int w         = 0;
    while ((acc_cnt - start_acc) < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(3) != 0);
      a         = N'($urandom);
      b         = N'($urandom);
      cin       = 1'($urandom_range(1));
      is_signed = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand_count_reached", (acc_cnt - start_acc) >= 10000, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rand_drained", exp_q.size(), 0);
    check("acc_eq_del", del_cnt, acc_cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_ovf", ovf, 0);
    check("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    lat_test("u_chain", 12'hFFF, 12'h000, 1'b1, 1'b0, 13'h1000, 1'b0);
    lat_test("s_ovf", 12'h7FF, 12'h001, 1'b0, 1'b1, 13'h0800, 1'b1);
    lat_test("s_neg", 12'hFFF, 12'hFFF, 1'b0, 1'b1, 13'h1FFE, 1'b0);
    mixed_test();
    backpressure_test();
    reset_test();
    random_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL take parameter N, default 12, giving the operand width in bits.
REQ-003 The block SHALL take parameter BLOCK, default 4, giving the carry-lookahead group width in bits.
REQ-004 The block SHALL provide the ports below.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  block accepts a transaction this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in.
- is_signed  in  1  per-transaction mode: 1 = two's complement, 0 = unsigned.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  N+1  result.
- ovf  out  1  signed overflow flag.

Function
REQ-005 A transaction SHALL be accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-006 Elaboration SHALL fail unless N % BLOCK == 0 and N >= BLOCK; NBLK = N/BLOCK.
REQ-007 The adder SHALL be split into NBLK lookahead groups; group k SHALL compute bits [k*BLOCK +: BLOCK] in pipeline stage k, using the group carry registered from stage k-1.
REQ-008 Operand bits for later groups and the already-computed sum bits SHALL travel in skew registers alongside the carry.
REQ-009 Latency SHALL be exactly NBLK cycles from acceptance to out_valid when not stalled, and throughput SHALL be one transaction per cycle.
REQ-010 Stall SHALL be defined as out_valid && !out_ready; in_ready SHALL equal !stall.
REQ-011 During a stall, all pipeline registers SHALL hold; otherwise all stages SHALL advance together, with bubbles propagating as invalid.
REQ-012 While stalled, sum, ovf and out_valid SHALL remain stable until the transaction is delivered.
REQ-013 For unsigned transactions: sum = zero-extended a + zero-extended b + cin, where sum[N] is the carry-out, and ovf = 0.
REQ-014 For signed transactions: sum = sign-extended a + sign-extended b + cin (N+1 bits, sign-correct), and ovf = carry into bit N-1 XOR carry out of bit N-1.
REQ-015 Mode SHALL travel with its transaction, so that mixed signed and unsigned transactions in flight SHALL each be computed correctly.
REQ-016 Results SHALL leave in acceptance order; no transaction SHALL be dropped or duplicated.
REQ-017 When in_valid is low, no transaction SHALL be accepted and the a, b, cin and is_signed values SHALL be ignored.

Reset
REQ-018 Asserting rst_n low SHALL asynchronously clear every stage valid bit, forcing out_valid = 0, sum = 0 and ovf = 0, which makes in_ready = 1.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight transactions; none SHALL appear after reset is released.
REQ-020 Data and skew registers MAY be left non-reset.
REQ-021 The first transaction accepted after release SHALL appear NBLK cycles later.

Structure
REQ-022 A shared package cla_pkg SHALL hold the function nblk(N, BLOCK) and the elaboration-check helper.
REQ-023 A single combinational sub-module cla_group (parameter BLOCK) SHALL be instantiated NBLK times.
- Inputs: a, b, cin.
- Outputs: sum[BLOCK-1:0], group generate, group propagate, carry-out, and carry into its MSB (used for ovf).
REQ-024 Only the top level SHALL contain registers.

Verification (N=12, BLOCK=4, NBLK=3)
REQ-025 Unsigned full-chain carry: a=0xFFF, b=0x000, cin=1, is_signed=0 -> sum=0x1000, ovf=0, out_valid exactly 3 cycles after accept.
REQ-026 Signed overflow: a=0x7FF, b=0x001, cin=0, is_signed=1 -> sum=0x0800, ovf=1; and a=0xFFF, b=0xFFF, is_signed=1 -> sum=0x1FFE, ovf=0.
REQ-027 Mixed stream: back-to-back accepts of (0xFFF,0x001,u), (0x800,0x800,s), (0x123,0x456,u) -> outputs in consecutive cycles, in order, equal to:
- 0x1000, ovf=0.
- 0x1000, ovf=1.
- 0x0579, ovf=0.
REQ-028 Backpressure: 5 consecutive transactions with out_ready low for 4 cycles once out_valid rises -> during the stall, in_ready=0 and sum is stable; afterwards all 5 results are delivered in order with none lost.
REQ-029 Reset mid-flight: accept 2 transactions, then pulse rst_n low for 1 cycle -> out_valid=0 immediately, and no stale result appears afterwards; a new transaction returns after 3 cycles.
REQ-030 Random regression: at least 10k random a, b, cin, mode values with random out_ready -> every result matches the reference model, and the accepted-transaction count equals the delivered count.
